// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx transmitter among NUM_REQ byte sources. Pending
// requests are served round-robin. Each accepted byte is launched with a
// one-cycle uart_send_en pulse. uart_tx_busy is then tracked through the
// frame. If busy never rises after a launch, the frame is abandoned after
// BUSY_TIMEOUT cycles.
//
// Parameters
//   NUM_REQ       number of requesters (>= 2)
//   BUSY_TIMEOUT  cycles to wait for uart_tx_busy after a launch (>= 4)
//
// Ports
//   sys_clk         in   1            system clock, rising edge
//   sys_rst         in   1            synchronous reset, active-high
//   req             in   NUM_REQ      level request per requester, held until ack
//   req_data        in   NUM_REQ*8    byte of requester i at [8*i+7:8*i]
//   req_ack         out  NUM_REQ      one-cycle pulse: byte of requester i taken
//   uart_tx_busy    in   1            busy flag from uart_tx
//   uart_send_en    out  1            one-cycle launch pulse to uart_tx
//   uart_send_data  out  8            launched byte, held until the next launch
//   grant_id        out  IDW          index of the last granted requester
//   busy_timeout    out  1            one-cycle pulse: launched byte never saw busy
//   arb_idle        out  1            high while the arbiter is idle
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned BUSY_TIMEOUT = 16,
    localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    input  logic                   uart_tx_busy,
    output logic                   uart_send_en,
    output logic [7:0]             uart_send_data,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy_timeout,
    output logic                   arb_idle
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    // Registered state and outputs
    state_t                r_state;
    logic [NUM_REQ-1:0]    r_ack;
    logic                  r_send_en;
    logic [7:0]            r_data;
    logic [IDW-1:0]        r_gid;
    logic [IDW-1:0]        r_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_to;

    // Next-state values
    state_t                w_state_nxt;
    logic [NUM_REQ-1:0]    w_ack_nxt;
    logic                  w_send_en_nxt;
    logic [7:0]            w_data_nxt;
    logic [IDW-1:0]        w_gid_nxt;
    logic [IDW-1:0]        w_ptr_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_to_nxt;

    // Arbitration results
    logic                  w_found;
    logic [IDW-1:0]        w_pick;
    logic [7:0]            w_pick_data;
    logic [CW-1:0]         w_cnt_inc;

    // Round-robin scan: the requester after the last grant is looked at
    // first, wrapping modulo NUM_REQ, and the first set request wins.
    always_comb begin : arb_scan
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && 1'(req >> idx)) begin
                w_found = 1'b1;
                w_pick  = IDW'(idx);
            end
        end
    end

    assign w_pick_data = 8'(req_data >> (8 * 32'(w_pick)));

    // Saturating increment of the busy-wait counter
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin : next_state
        w_state_nxt   = r_state;
        w_ack_nxt     = '0;
        w_send_en_nxt = 1'b0;
        w_data_nxt    = r_data;
        w_gid_nxt     = r_gid;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_to_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A busy transmitter blocks every grant.
                if (w_found && !uart_tx_busy) begin
                    w_ack_nxt     = NUM_REQ'(1) << w_pick;
                    w_send_en_nxt = 1'b1;
                    w_data_nxt    = w_pick_data;
                    w_gid_nxt     = w_pick;
                    w_ptr_nxt     = w_pick;
                    w_state_nxt   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    // Abandon the frame: the byte counts as consumed and the
                    // pointer stays on its requester.
                    if (w_cnt_inc >= CW'(BUSY_TIMEOUT - 1)) begin
                        w_to_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_ack     <= '0;
            r_send_en <= 1'b0;
            r_data    <= '0;
            r_gid     <= '0;
            r_ptr     <= IDW'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_to      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_send_en <= w_send_en_nxt;
            r_data    <= w_data_nxt;
            r_gid     <= w_gid_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_to      <= w_to_nxt;
        end
    end

    assign req_ack        = r_ack;
    assign uart_send_en   = r_send_en;
    assign uart_send_data = r_data;
    assign grant_id       = r_gid;
    assign busy_timeout   = r_to;
    assign arb_idle       = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=16).
// A uart_tx busy model raises busy 2 cycles after each launch for 20 cycles.
// Every launch is matched against a queue of expected {requester, byte}.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ack;
    logic        uart_tx_busy;
    logic        uart_send_en;
    logic [7:0]  uart_send_data;
    logic [0:0]  grant_id;
    logic        busy_timeout;
    logic        arb_idle;

    uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TIMEOUT(16)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .req            (req),
        .req_data       (req_data),
        .req_ack        (req_ack),
        .uart_tx_busy   (uart_tx_busy),
        .uart_send_en   (uart_send_en),
        .uart_send_data (uart_send_data),
        .grant_id       (grant_id),
        .busy_timeout   (busy_timeout),
        .arb_idle       (arb_idle)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // uart_tx busy model
    logic se_d = 1'b0;
    int   bm_cnt = 0;
    bit   bm_en = 1'b1;
    logic busy_force = 1'b0;
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            se_d   <= 1'b0;
            bm_cnt <= 0;
        end else begin
            se_d <= uart_send_en & bm_en;
            if (se_d) bm_cnt <= 20;
            else if (bm_cnt != 0) bm_cnt <= bm_cnt - 1;
        end
    end
    assign uart_tx_busy = busy_force | (bm_cnt != 0);

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Scoreboard
    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int n_launch = 0;
    int prev_launch = -100;

    always @(negedge sys_clk) begin
        if (uart_send_en || req_ack != '0) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_launch: got send_en=%b ack=%b data=0x%0h, required no launch",
                         uart_send_en, req_ack, uart_send_data);
            end else begin
                exp_t e;
                logic [1:0] oh;
                e  = sb.pop_front();
                oh = 2'b01 << e.id;
                chk("launch_send_en", uart_send_en, 1);
                chk("launch_ack", req_ack, oh);
                chk("launch_data", uart_send_data, e.data);
                chk("launch_grant_id", grant_id, e.id);
            end
            chk("pulse_spacing_ge3", (cyc - prev_launch) >= 3, 1);
            prev_launch = cyc;
            n_launch++;
        end
    end

    task automatic wait_ack(input int t0, input string tag, output int ack_cyc);
        bit got;
        got = 1'b0;
        ack_cyc = -1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge sys_clk);
            if (req_ack != '0) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s_ack_timeout: got no req_ack in 60 cycles, required an ack", tag);
        end else begin
            chk({tag, "_ack_latency"}, ack_cyc - t0, 1);
        end
    endtask

    // Present a request in an idle cycle, expect it launched next cycle,
    // then drop it the cycle after the ack.
    task automatic launch(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                          input int exp_id, input logic [7:0] exp_d, input string tag,
                          output int ack_cyc);
        int t0;
        @(posedge sys_clk); #1;
        req = rq;
        req_data = {d1, d0};
        t0 = cyc;
        sb.push_back('{exp_id, exp_d});
        wait_ack(t0, tag, ack_cyc);
        @(posedge sys_clk); #1;
        req = '0;
    endtask

    task automatic wait_idle(input string tag, output int idle_cyc);
        bit got;
        got = 1'b0;
        idle_cyc = -1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge sys_clk);
            if (arb_idle) begin
                got = 1'b1;
                idle_cyc = cyc;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s_idle_timeout: got arb_idle=0 for 60 cycles, required 1", tag);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_send_en"}, uart_send_en, 0);
        chk({tag, "_data"}, uart_send_data, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_busy_timeout"}, busy_timeout, 0);
        chk({tag, "_arb_idle"}, arb_idle, 1);
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [7:0] d0;
        logic [7:0] d1;
        int         exp_id;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, id, n0, t0, to_cyc;
        int acks[4];
        int nack;

        // Pointer starts at 1, so requester 0 wins the first contest.
        vecs[0] = '{2'b01, 8'h55, 8'h00, 0, 8'h55};
        vecs[1] = '{2'b10, 8'h00, 8'h3C, 1, 8'h3C};
        vecs[2] = '{2'b11, 8'h11, 8'h22, 0, 8'h11};
        vecs[3] = '{2'b11, 8'h33, 8'h44, 1, 8'h44};
        vecs[4] = '{2'b10, 8'h00, 8'h66, 1, 8'h66};
        vecs[5] = '{2'b01, 8'h77, 8'h00, 0, 8'h77};
        vecs[6] = '{2'b11, 8'h88, 8'h99, 1, 8'h99};
        vecs[7] = '{2'b11, 8'hAA, 8'hBB, 0, 8'hAA};

        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_vals("por");
        sys_rst = 1'b0;

        // Single launches, including test 1 in row 0
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].rq, vecs[i].d0, vecs[i].d1, vecs[i].exp_id, vecs[i].exp_d,
                   $sformatf("row%0d", i), a);
            wait_idle($sformatf("row%0d", i), id);
            chk($sformatf("row%0d_idle_after_busy", i), id - a, 23);
        end

        // Both requesting continuously from reset: A1,B2,A1,B2
        @(posedge sys_clk); #1; sys_rst = 1'b1;
        @(posedge sys_clk); #1; sys_rst = 1'b0;
        req = 2'b11;
        req_data = {8'hB2, 8'hA1};
        t0 = cyc;
        sb.push_back('{0, 8'hA1});
        sb.push_back('{1, 8'hB2});
        sb.push_back('{0, 8'hA1});
        sb.push_back('{1, 8'hB2});
        nack = 0;
        for (int n = 0; n < 200 && nack < 4; n++) begin
            @(negedge sys_clk);
            if (req_ack != '0) begin
                acks[nack] = cyc;
                nack++;
            end
        end
        @(posedge sys_clk); #1;
        req = '0;
        chk("rr_ack_count", nack, 4);
        if (nack == 4) begin
            chk("rr_first_latency", acks[0] - t0, 1);
            chk("rr_frame_period", acks[1] - acks[0], 24);
            chk("rr_frame_period2", acks[3] - acks[2], 24);
        end
        wait_idle("rr", id);

        // Busy held in IDLE blocks the grant
        @(posedge sys_clk); #1;
        busy_force = 1'b1;
        req = 2'b10;
        req_data = {8'hC3, 8'h00};
        n0 = n_launch;
        repeat (8) @(negedge sys_clk);
        chk("busyhold_no_launch", n_launch, n0);
        chk("busyhold_idle", arb_idle, 1);
        @(posedge sys_clk); #1;
        busy_force = 1'b0;
        t0 = cyc;
        sb.push_back('{1, 8'hC3});
        wait_ack(t0, "busyhold", a);
        @(posedge sys_clk); #1;
        req = '0;
        wait_idle("busyhold", id);

        // busy never rises: timeout 16 cycles after LAUNCH
        bm_en = 1'b0;
        launch(2'b01, 8'h5A, 8'h00, 0, 8'h5A, "tmo", a);
        n0 = n_launch;
        to_cyc = -1;
        for (int n = 0; n < 40 && to_cyc < 0; n++) begin
            @(negedge sys_clk);
            if (busy_timeout) to_cyc = cyc;
        end
        if (to_cyc < 0) begin
            n_total++;
            $display("FAIL tmo_pulse: got no busy_timeout in 40 cycles, required a pulse");
        end else begin
            chk("tmo_delay", to_cyc - a, 16);
            chk("tmo_idle", arb_idle, 1);
            @(negedge sys_clk);
            chk("tmo_one_cycle", busy_timeout, 0);
        end
        repeat (30) @(posedge sys_clk);
        #1;
        chk("tmo_no_second_send", n_launch, n0);
        chk("tmo_data_held", uart_send_data, 8'h5A);
        bm_en = 1'b1;

        // Reset during WAIT_DONE; pointer returns so requester 0 wins
        launch(2'b01, 8'h12, 8'h00, 0, 8'h12, "rst", a);
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        chk_reset_vals("midrst");
        req = 2'b11;
        req_data = {8'h9B, 8'h9A};
        t0 = cyc;
        sb.push_back('{0, 8'h9A});
        wait_ack(t0, "postrst", a);
        @(posedge sys_clk); #1;
        req = '0;
        wait_idle("postrst", id);

        // Request withdrawn before it could be granted
        launch(2'b01, 8'h61, 8'h00, 0, 8'h61, "wdraw", a);
        repeat (4) @(posedge sys_clk);
        #1;
        req = 2'b10;
        req_data = {8'hEE, 8'h61};
        @(posedge sys_clk); #1;
        req = '0;
        n0 = n_launch;
        wait_idle("wdraw", id);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("wdraw_no_launch", n_launch, n0);
        chk("wdraw_data_held", uart_send_data, 8'h61);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
